bus_arbiter4: RTL and testbench
===============================

BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 The module SHALL have one parameter: HOLD_MAX, default 16, the maximum number of cycles a grant is held; it is used only when ARB_TIMEOUT_EN is defined.
REQ-002 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port reset: input, 1 bit, synchronous active-high reset.
REQ-004 Port req: input, 4 bits, one request line per requester, index = requester ID 0..3.
REQ-005 Port done: input, 4 bits, a release pulse from each requester.
REQ-006 Port grant: output, 4 bits, one-hot grant, or all zeros.
REQ-007 Port sel: output, 2 bits, encoded owner ID; it drives the shared 4:1 operand/result mux select line (00=a, 01=b, 10=c, 11=d).
REQ-008 Port busy: output, 1 bit, high while any grant is active.
REQ-009 Port timeout: output, 1 bit, a one-cycle pulse on forced release.

Function
REQ-010 The controller SHALL be a two-state FSM: IDLE and OWNED.
REQ-011 In IDLE with req != 0, the controller SHALL pick a winner round-robin.
  - Search order starts at last+1 mod 4, where last is the ID of the previous owner.
  - On the next edge: FSM goes to OWNED, grant = one-hot(winner), sel = winner, busy = 1, last = winner.
REQ-012 Grant latency SHALL be exactly 1 cycle from the req sample in IDLE to grant visible.
REQ-013 In IDLE with req == 0, all registers SHALL hold; grant stays 0 and busy stays 0.
REQ-014 In OWNED, grant and sel SHALL hold while req[owner]=1 and done[owner]=0.
REQ-015 Release condition SHALL be done[owner]=1 or req[owner]=0.
  - On the next edge: grant = 0, busy = 0, FSM goes to IDLE.
  - sel SHALL keep the last owner value, so the mux output stays stable.
REQ-016 After every release there SHALL be exactly one IDLE bubble cycle before the next grant (bus turnaround).
REQ-017 done bits and req changes of non-owners SHALL be ignored while OWNED.
REQ-018 If done[owner] and a timeout expiry coincide, the release SHALL be treated as normal: timeout stays 0.
REQ-019 grant SHALL never have more than one bit set.
REQ-020 sel SHALL equal the index of the set grant bit whenever busy=1.
REQ-021 Simultaneous requests SHALL be resolved by round-robin only.
  - Under continuous contention, each requester is served at least once in every 4 grants.

Reset
REQ-022 On reset=1 at a clock edge, the following SHALL take effect on that edge regardless of FSM state:
  - grant=0000, sel=00, busy=0, timeout=0.
  - FSM = IDLE, last = 3, so requester 0 has first priority.
  - The hold counter is cleared.
REQ-023 Reset asserted mid-grant SHALL drop the grant on that edge, with no timeout pulse.
REQ-024 On the first edge with reset=0, normal arbitration SHALL apply to the sampled req.

Configuration
REQ-025 The forced-release feature SHALL be controlled by macro ARB_TIMEOUT_EN.
REQ-026 With ARB_TIMEOUT_EN defined:
  - A hold counter SHALL clear on entering OWNED and increment each OWNED cycle.
  - When it reaches HOLD_MAX-1 with no release condition, the next edge SHALL force release (as in REQ-015) and pulse timeout=1 for one cycle.
  - The grant therefore lasts exactly HOLD_MAX cycles.
  - last SHALL advance normally.
REQ-027 Without ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be constant 0, and a grant SHALL be held indefinitely.

Verification
REQ-028 Single requester: reset; req=0100 at cycle 0 -> grant=0100, sel=10, busy=1 at cycle 1; done=0100 at cycle 4 -> grant=0000 at cycle 5, sel stays 10.
REQ-029 Contention fairness: req=1111 held, each owner pulses done one cycle after its grant -> grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
REQ-030 Reset mid-grant: owner=3, reset pulse -> grant=0000, sel=00, timeout=0 on that edge; then req=1001 -> requester 0 granted.
REQ-031 Non-owner done ignored: owner=1, done=1101 -> grant stays 0010.
REQ-032 Timeout with ARB_TIMEOUT_EN, HOLD_MAX=16: owner=2, req held, done=0 -> grant active exactly 16 cycles, timeout=1 for one cycle at the release edge, next grant goes to 3 if req[3]=1. Without the macro: grant still held after 100 cycles, timeout never 1.
REQ-033 Release via req drop: owner=0, req[0] falls -> grant=0000 on the next edge, busy=0, with no done required.

Source files
------------

// File: rtl/bus_arbiter4_if.sv
// Request/grant bundle between four requesters and the bus_arbiter4 controller.
// master = requester side (drives req/done), slave = arbiter side (drives grant/sel/busy/timeout).
interface bus_arbiter4_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output sel,
    output busy,
    output timeout
  );
endinterface

// File: rtl/bus_arbiter4.sv
// Four-way round-robin bus arbiter with one-cycle grant latency and a turnaround bubble.
// Optional forced release after HOLD_MAX cycles is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter4 #(
  parameter int HOLD_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter4_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  if (HOLD_MAX < 1) begin : g_bad_hold_max
    $error("bus_arbiter4: HOLD_MAX must be at least 1");
  end

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;

  logic [1:0] cand;
  logic [1:0] winner;
  logic       req_found;
  logic       owner_release;
  logic       force_release;

  // Round-robin search begins just after the previous owner and wraps modulo 4.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    cand      = '0;
    winner    = '0;
    req_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + i[1:0];
      if (!req_found && bus.req[cand]) begin
        winner    = cand;
        req_found = 1'b1;
      end
    end
  end

  assign owner_release = bus.done[sel_q] | ~bus.req[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign force_release = (state_q == OWNED) && (cnt_q == CNT_W'(HOLD_MAX - 1)) && !owner_release;

  always_comb begin
    cnt_d     = '0;
    timeout_d = force_release;
    if (state_q == OWNED && state_d == OWNED) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_release = 1'b0;
  assign bus.timeout   = 1'b0;
`endif

  // State register: reset wins over everything, including a grant in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_found) state_d = OWNED;
      OWNED:   if (owner_release || force_release) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sel keeps the last owner after release so the shared operand mux stays stable.
  always_comb begin
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          last_d  = winner;
        end
      end
      OWNED: begin
        if (owner_release || force_release) begin
          grant_d = '0;
        end
      end
      default: grant_d = '0;
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = (state_q == OWNED);

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed scoreboard bench for bus_arbiter4; expectations are queued as stimulus is driven.
module tb_bus_arbiter4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   chk_en;

  string      tag_q[$];
  logic [7:0] exp_q[$];

  bus_arbiter4_if bus ();

  bus_arbiter4 #(.HOLD_MAX(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] onehot(input int id);
    logic [3:0] v;
    v = 4'b0001 << id;
    return v;
  endfunction

  // Drive at the falling edge, queue the expected post-edge outputs, compare 1 ns after the rising edge.
  task automatic step(input string tag, input logic rst_v, input logic [3:0] r, input logic [3:0] d,
                      input logic [3:0] eg, input logic [1:0] es, input logic eb, input logic et);
    string      t;
    logic [7:0] e;
    logic [7:0] obs;
    @(negedge clk);
    reset    = rst_v;
    bus.req  = r;
    bus.done = d;
    tag_q.push_back(tag);
    exp_q.push_back({eg, es, eb, et});
    @(posedge clk);
    #1;
    t   = tag_q.pop_front();
    e   = exp_q.pop_front();
    obs = {bus.grant, bus.sel, bus.busy, bus.timeout};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed grant/sel/busy/timeout=%b_%b_%b_%b expected %b_%b_%b_%b",
             t, obs[7:4], obs[3:2], obs[1], obs[0], e[7:4], e[3:2], e[1], e[0]);
    end
  endtask

  // Structural invariant: grant is zero when idle, otherwise exactly the bit selected by sel.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      assert (bus.grant === (bus.busy ? onehot(int'(bus.sel)) : 4'b0000)) else begin
        errors++;
        $error("FAIL invariant: observed grant=%b sel=%b busy=%b", bus.grant, bus.sel, bus.busy);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    chk_en   = 1'b0;
    reset    = 1'b1;
    bus.req  = '0;
    bus.done = '0;

    step("reset_state", 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("reset_overrides_req", 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
    chk_en = 1'b1;

    // Single requester 2, released by done.
    step("single_grant", 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      step($sformatf("single_hold_%0d", k), 1'b0, 4'b0100, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0);
    step("single_done_release", 1'b0, 4'b0100, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0);
    step("idle_no_req_holds", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0);
    step("idle_no_req_holds2", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0);

    // Fairness under full contention, starting from reset priority.
    step("rr_reset", 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step($sformatf("rr_grant_%0d", k), 1'b0, 4'b1111, 4'b0000, onehot(k % 4), 2'((k % 4)), 1'b1, 1'b0);
      step($sformatf("rr_release_%0d", k), 1'b0, 4'b1111, onehot(k % 4), 4'b0000, 2'((k % 4)), 1'b0, 1'b0);
    end

    // Owner 1 ignores done from non-owners and req changes of others.
    step("own1_grant", 1'b0, 4'b0010, 4'b0000, 4'b0010, 2'b01, 1'b1, 1'b0);
    step("own1_other_done", 1'b0, 4'b1111, 4'b1101, 4'b0010, 2'b01, 1'b1, 1'b0);
    step("own1_other_req_chg", 1'b0, 4'b0011, 4'b1101, 4'b0010, 2'b01, 1'b1, 1'b0);
    step("own1_release", 1'b0, 4'b0011, 4'b0010, 4'b0000, 2'b01, 1'b0, 1'b0);

    // Owner 0 released by dropping its own request.
    step("own0_grant", 1'b0, 4'b0001, 4'b0000, 4'b0001, 2'b00, 1'b1, 1'b0);
    step("own0_hold", 1'b0, 4'b0001, 4'b0000, 4'b0001, 2'b00, 1'b1, 1'b0);
    step("own0_req_drop", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);

    // Reset in the middle of a grant to requester 3.
    step("own3_grant", 1'b0, 4'b1000, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0);
    step("own3_hold", 1'b0, 4'b1000, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0);
    step("midgrant_reset", 1'b1, 4'b1000, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("post_reset_prio0", 1'b0, 4'b1001, 4'b0000, 4'b0001, 2'b00, 1'b1, 1'b0);
    step("post_reset_release", 1'b0, 4'b1001, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("rr_skip_to_3", 1'b0, 4'b1001, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0);
    step("own3_req_drop", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0);

    // Long hold by requester 2 with requester 3 waiting.
    step("long_grant2", 1'b0, 4'b1100, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 15; k++)
      step($sformatf("to_hold_%0d", k), 1'b0, 4'b1100, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0);
    step("to_forced_release", 1'b0, 4'b1100, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b1);
    step("to_next_grant3", 1'b0, 4'b1100, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++)
      step($sformatf("co_hold_%0d", k), 1'b0, 4'b1000, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0);
    step("done_at_expiry_no_to", 1'b0, 4'b1000, 4'b1000, 4'b0000, 2'b11, 1'b0, 1'b0);
`else
    for (int k = 0; k < 100; k++)
      step($sformatf("nto_hold_%0d", k), 1'b0, 4'b1100, 4'b0000, 4'b0100, 2'b10, 1'b1, 1'b0);
    step("nto_done_release", 1'b0, 4'b1100, 4'b0100, 4'b0000, 2'b10, 1'b0, 1'b0);
    step("nto_next_grant3", 1'b0, 4'b1100, 4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0);
    step("nto_release3", 1'b0, 4'b0100, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0);
`endif
    step("final_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0);

    chk_en = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
